voice_mix_accumulator: RTL and testbench

Time-multiplexed voice mixer for the FM synthesizer. Once per audio frame it reads every voice's oscillator output and applies a per-voice route (output channel, gain, mute). It sums the results into NUM_OUTPUTS accumulators, saturates them, and presents one packed output frame to the I2S core through a valid/ready handshake. It sits between the voice interpolators and the I2S sample-request logic.

---
 rtl/fm_mix_pkg.sv | 21 ++
 rtl/voice_route_regfile.sv | 71 +++++++
 rtl/voice_mix_accumulator.sv | 216 +++++++++++++++++++++
 tb/tb_voice_mix_accumulator.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_mix_pkg.sv
// Shared types, gain format constants and saturation helper for the FM voice mixer.
package fm_mix_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, LOAD} mix_state_e;

  localparam int unsigned GAIN_W    = 16;
  localparam int unsigned GAIN_FRAC = 15;

  // Clamp a sign-extended value into the signed range of a `width`-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] val,
                                                  input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (val > hi) return hi;
    if (val < lo) return lo;
    return val;
  endfunction

endpackage

// File: rtl/voice_route_regfile.sv
// Per-voice route table {chan, gain, mute}: synchronous write, combinational read.
// Writes to voice indices outside the table are dropped; reset restores round-robin routing at unity gain.
module voice_route_regfile
  import fm_mix_pkg::*;
#(
  parameter int NUM_VOICES  = 10,
  parameter int VOICE_AW    = 4,
  parameter int NUM_OUTPUTS = 4,
  parameter int OUT_AW      = 2
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                wr_en,
  input  logic [VOICE_AW-1:0] wr_voice,
  input  logic [OUT_AW-1:0]   wr_chan,
  input  logic [GAIN_W-1:0]   wr_gain,
  input  logic                wr_mute,
  input  logic [VOICE_AW-1:0] rd_voice,
  output logic [OUT_AW-1:0]   rd_chan,
  output logic [GAIN_W-1:0]   rd_gain,
  output logic                rd_mute
);

  logic [OUT_AW-1:0] chan_q [NUM_VOICES];
  logic [OUT_AW-1:0] chan_d [NUM_VOICES];
  logic [GAIN_W-1:0] gain_q [NUM_VOICES];
  logic [GAIN_W-1:0] gain_d [NUM_VOICES];
  logic              mute_q [NUM_VOICES];
  logic              mute_d [NUM_VOICES];

  always_comb begin
    chan_d = chan_q;
    gain_d = gain_q;
    mute_d = mute_q;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (wr_en && wr_voice == VOICE_AW'(v)) begin
        chan_d[v] = wr_chan;
        gain_d[v] = wr_gain;
        mute_d[v] = wr_mute;
      end
    end
  end

  always_comb begin
    rd_chan = '0;
    rd_gain = '0;
    rd_mute = 1'b0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (rd_voice == VOICE_AW'(v)) begin
        rd_chan = chan_q[v];
        rd_gain = gain_q[v];
        rd_mute = mute_q[v];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        chan_q[v] <= OUT_AW'(v % NUM_OUTPUTS);
        gain_q[v] <= 16'h7FFF;
        mute_q[v] <= 1'b0;
      end
    end else begin
      chan_q <= chan_d;
      gain_q <= gain_d;
      mute_q <= mute_d;
    end
  end

endmodule

// File: rtl/voice_mix_accumulator.sv
// Frame mixer: fetches NUM_VOICES samples, routes/sums them per channel, saturates; out_valid at N+3 (N+4 with MIX_GAIN_EN).
// Output held until out_valid&out_ready; a new frame overwrites an unaccepted one and pulses overrun.
module voice_mix_accumulator
  import fm_mix_pkg::*;
#(
  parameter int NUM_VOICES  = 10,
  parameter int VOICE_AW    = 4,
  parameter int NUM_OUTPUTS = 4,
  parameter int OUT_AW      = 2,
  parameter int DW          = 32,
  parameter int OW          = 24
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      frame_start,
  output logic                      voice_req,
  output logic [VOICE_AW-1:0]       voice_idx,
  input  logic [DW-1:0]             voice_data,
  input  logic                      cfg_wr,
  input  logic [VOICE_AW-1:0]       cfg_voice,
  input  logic [OUT_AW-1:0]         cfg_chan,
  input  logic [15:0]               cfg_gain,
  input  logic                      cfg_mute,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_OUTPUTS*OW-1:0] out_data,
  output logic                      busy,
  output logic                      overrun
);

  localparam int AW = DW + VOICE_AW;
`ifdef MIX_GAIN_EN
  localparam int DRAIN_CYC = 2;
`else
  localparam int DRAIN_CYC = 1;
`endif

  mix_state_e                state_q, state_d;
  logic [VOICE_AW-1:0]       voice_idx_q, voice_idx_d;
  logic [1:0]                drain_q, drain_d;
  logic                      out_valid_q, out_valid_d;
  logic [NUM_OUTPUTS*OW-1:0] out_data_q, out_data_d;
  logic                      overrun_q, overrun_d;
  logic                      acc_clr, load;

  logic [OUT_AW-1:0]         rd_chan;
  logic [GAIN_W-1:0]         rd_gain;
  logic                      rd_mute;

  logic                      p1_vld_q, p1_vld_d;
  logic [OUT_AW-1:0]         p1_chan_q, p1_chan_d;
  logic                      p1_mute_q, p1_mute_d;

  logic                      add_vld;
  logic [OUT_AW-1:0]         add_chan;
  logic signed [AW-1:0]      addend;

  logic signed [AW-1:0]      acc_q [NUM_OUTPUTS];
  logic signed [AW-1:0]      acc_d [NUM_OUTPUTS];
  logic [NUM_OUTPUTS*OW-1:0] sat_frame;

  voice_route_regfile #(
    .NUM_VOICES  (NUM_VOICES),
    .VOICE_AW    (VOICE_AW),
    .NUM_OUTPUTS (NUM_OUTPUTS),
    .OUT_AW      (OUT_AW)
  ) u_routes (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .wr_en    (cfg_wr),
    .wr_voice (cfg_voice),
    .wr_chan  (cfg_chan),
    .wr_gain  (cfg_gain),
    .wr_mute  (cfg_mute),
    .rd_voice (voice_idx_q),
    .rd_chan  (rd_chan),
    .rd_gain  (rd_gain),
    .rd_mute  (rd_mute)
  );

  always_comb begin
    state_d     = state_q;
    voice_idx_d = voice_idx_q;
    drain_d     = drain_q;
    acc_clr     = 1'b0;
    load        = 1'b0;
    overrun_d   = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d     = FETCH;
          voice_idx_d = '0;
          acc_clr     = 1'b1;
        end
      end
      FETCH: begin
        if (voice_idx_q == VOICE_AW'(NUM_VOICES - 1)) begin
          state_d     = DRAIN;
          voice_idx_d = '0;
          drain_d     = '0;
        end else begin
          voice_idx_d = voice_idx_q + VOICE_AW'(1);
        end
      end
      DRAIN: begin
        if (drain_q == 2'(DRAIN_CYC - 1)) state_d = LOAD;
        else                              drain_d = drain_q + 2'd1;
      end
      LOAD: begin
        load    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (frame_start && state_q != IDLE) overrun_d = 1'b1;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    // Consumption in the load cycle frees the slot, so only a stalled consumer is an overrun.
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = sat_frame;
      if (out_valid_q && !out_ready) overrun_d = 1'b1;
    end
  end

  assign p1_vld_d  = (state_q == FETCH);
  assign p1_chan_d = rd_chan;
  assign p1_mute_d = rd_mute;

`ifdef MIX_GAIN_EN
  logic [GAIN_W-1:0]          p1_gain_q;
  logic                       p2_vld_q, p2_vld_d;
  logic [OUT_AW-1:0]          p2_chan_q, p2_chan_d;
  logic signed [DW-1:0]       p2_term_q, p2_term_d;
  logic signed [DW+GAIN_W-1:0] prod;

  always_comb begin
    prod      = $signed(voice_data) * $signed(p1_gain_q);
    p2_vld_d  = p1_vld_q;
    p2_chan_d = p1_chan_q;
    p2_term_d = p1_mute_q ? '0 : DW'(prod >>> GAIN_FRAC);
  end

  assign add_vld  = p2_vld_q;
  assign add_chan = p2_chan_q;
  assign addend   = AW'(p2_term_q);
`else
  logic unused_gain;
  assign unused_gain = ^rd_gain;

  assign add_vld  = p1_vld_q;
  assign add_chan = p1_chan_q;
  assign addend   = p1_mute_q ? '0 : AW'($signed(voice_data));
`endif

  always_comb begin
    for (int c = 0; c < NUM_OUTPUTS; c++) begin
      acc_d[c] = acc_clr ? '0 : acc_q[c];
      if (add_vld && add_chan == OUT_AW'(c)) acc_d[c] = acc_q[c] + addend;
    end
  end

  always_comb begin
    sat_frame = '0;
    for (int c = 0; c < NUM_OUTPUTS; c++) begin
      sat_frame[c*OW +: OW] = OW'(saturate(64'(acc_q[c]) >>> (DW - OW), OW));
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      voice_idx_q <= '0;
      drain_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overrun_q   <= 1'b0;
      p1_vld_q    <= 1'b0;
      p1_chan_q   <= '0;
      p1_mute_q   <= 1'b0;
      for (int c = 0; c < NUM_OUTPUTS; c++) acc_q[c] <= '0;
`ifdef MIX_GAIN_EN
      p1_gain_q   <= '0;
      p2_vld_q    <= 1'b0;
      p2_chan_q   <= '0;
      p2_term_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      voice_idx_q <= voice_idx_d;
      drain_q     <= drain_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overrun_q   <= overrun_d;
      p1_vld_q    <= p1_vld_d;
      p1_chan_q   <= p1_chan_d;
      p1_mute_q   <= p1_mute_d;
      acc_q       <= acc_d;
`ifdef MIX_GAIN_EN
      p1_gain_q   <= rd_gain;
      p2_vld_q    <= p2_vld_d;
      p2_chan_q   <= p2_chan_d;
      p2_term_q   <= p2_term_d;
`endif
    end
  end

  assign voice_req = (state_q == FETCH);
  assign voice_idx = voice_idx_q;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_voice_mix_accumulator.sv
// Directed bench for voice_mix_accumulator in its default build: vector table plus handshake/reset sequences.
module tb_voice_mix_accumulator;

  localparam int NV = 10;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        voice_req;
  logic [3:0]  voice_idx;
  logic [31:0] voice_data = '0;
  logic        cfg_wr = 1'b0;
  logic [3:0]  cfg_voice = '0;
  logic [1:0]  cfg_chan = '0;
  logic [15:0] cfg_gain = '0;
  logic        cfg_mute = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [95:0] out_data;
  logic        busy;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  int ovr_base;
  logic [31:0] vdata [NV];

  typedef struct {
    logic [1:0]  mode;   // 0: v mod 4, 1: all to ch0, 2: all to ch3
    logic [9:0]  mute;
    logic [31:0] d0;     // even voices
    logic [31:0] d1;     // odd voices
    logic [23:0] e0, e1, e2, e3;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  voice_mix_accumulator dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .voice_req   (voice_req),
    .voice_idx   (voice_idx),
    .voice_data  (voice_data),
    .cfg_wr      (cfg_wr),
    .cfg_voice   (cfg_voice),
    .cfg_chan    (cfg_chan),
    .cfg_gain    (cfg_gain),
    .cfg_mute    (cfg_mute),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (overrun) ovr_cnt++;

  // Voice source: answers a fetch one cycle after voice_req.
  initial begin
    logic       req_s;
    logic [3:0] idx_s;
    forever begin
      @(negedge Clk);
      req_s = voice_req;
      idx_s = voice_idx;
      @(posedge Clk);
      #1;
      voice_data = req_s ? vdata[idx_s] : 32'h0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg_routes(input logic [1:0] mode, input logic [9:0] mute);
    for (int v = 0; v < NV; v++) begin
      cfg_wr    = 1'b1;
      cfg_voice = 4'(v);
      cfg_chan  = (mode == 2'd0) ? 2'(v % 4) : (mode == 2'd1) ? 2'd0 : 2'd3;
      cfg_gain  = 16'h7FFF;
      cfg_mute  = mute[v];
      @(posedge Clk);
      #1;
    end
    cfg_wr = 1'b0;
  endtask

  task automatic set_data(input logic [31:0] d0, input logic [31:0] d1);
    for (int v = 0; v < NV; v++) vdata[v] = (v % 2 == 1) ? d1 : d0;
  endtask

  // Starts a frame in the current cycle (cycle 0) and runs until busy falls.
  task automatic start_and_wait(input int fs_again, input int rdy_at, input int mute0_at,
                                input string tag);
    int cyc;
    frame_start = 1'b1;
    cyc = 0;
    do begin
      @(posedge Clk);
      #1;
      cyc++;
      frame_start = (cyc == fs_again);
      out_ready   = (cyc == rdy_at);
      if (cyc == mute0_at) begin
        cfg_wr = 1'b1; cfg_voice = 4'd0; cfg_chan = 2'd0; cfg_gain = 16'h7FFF; cfg_mute = 1'b1;
      end else begin
        cfg_wr = 1'b0;
      end
      if (cyc == 1) begin
        chk({tag, "_busy_c1"}, 64'(busy), 64'd1);
        chk({tag, "_req_c1"}, 64'(voice_req), 64'd1);
        chk({tag, "_idx_c1"}, 64'(voice_idx), 64'd0);
      end
      if (cyc == NV) chk({tag, "_idx_last"}, 64'(voice_idx), 64'(NV - 1));
    end while (busy && cyc < 60);
    frame_start = 1'b0;
    out_ready   = 1'b0;
    cfg_wr      = 1'b0;
    chk({tag, "_latency"}, 64'(cyc), 64'(NV + 3));
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
  endtask

  task automatic check_out(input string tag, input logic [23:0] e0, input logic [23:0] e1,
                           input logic [23:0] e2, input logic [23:0] e3);
    chk({tag, "_ch0"}, 64'(out_data[0  +: 24]), 64'(e0));
    chk({tag, "_ch1"}, 64'(out_data[24 +: 24]), 64'(e1));
    chk({tag, "_ch2"}, 64'(out_data[48 +: 24]), 64'(e2));
    chk({tag, "_ch3"}, 64'(out_data[72 +: 24]), 64'(e3));
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    @(posedge Clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_valid_clr"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{2'd0, 10'h000, 32'h0000_0100, 32'h0000_0100, 24'h000003, 24'h000003, 24'h000002, 24'h000002};
    vecs[1]  = '{2'd1, 10'h000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 24'h7FFFFF, 24'h000000, 24'h000000, 24'h000000};
    vecs[2]  = '{2'd1, 10'h000, 32'h8000_0000, 32'h8000_0000, 24'h800000, 24'h000000, 24'h000000, 24'h000000};
    vecs[3]  = '{2'd0, 10'h000, 32'h0000_1000, 32'hFFFF_F000, 24'h000030, 24'hFFFFD0, 24'h000020, 24'hFFFFE0};
    vecs[4]  = '{2'd0, 10'h01F, 32'h0000_0100, 32'h0000_0100, 24'h000001, 24'h000002, 24'h000001, 24'h000001};
    vecs[5]  = '{2'd2, 10'h000, 32'h0000_00FF, 32'h0000_0001, 24'h000000, 24'h000000, 24'h000000, 24'h000005};
    vecs[6]  = '{2'd0, 10'h000, 32'hFFFF_FF01, 32'hFFFF_FF01, 24'hFFFFFD, 24'hFFFFFD, 24'hFFFFFE, 24'hFFFFFE};
    vecs[7]  = '{2'd1, 10'h3FE, 32'h7FFF_FF00, 32'h0000_0000, 24'h7FFFFF, 24'h000000, 24'h000000, 24'h000000};
    vecs[8]  = '{2'd1, 10'h3FC, 32'h7FFF_FF00, 32'h0000_0100, 24'h7FFFFF, 24'h000000, 24'h000000, 24'h000000};
    vecs[9]  = '{2'd1, 10'h3FC, 32'h8000_0000, 32'hFFFF_FF00, 24'h800000, 24'h000000, 24'h000000, 24'h000000};
    vecs[10] = '{2'd1, 10'h3FE, 32'h8000_0000, 32'h0000_0000, 24'h800000, 24'h000000, 24'h000000, 24'h000000};

    set_data(32'h0, 32'h0);
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_in_req", 64'(voice_req), 64'd0);
    chk("rst_in_busy", 64'(busy), 64'd0);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    chk("rst_req", 64'(voice_req), 64'd0);
    chk("rst_idx", 64'(voice_idx), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data[63:0]) | 64'(out_data[95:64]), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);

    // Reset-default routes, untouched by any cfg write.
    set_data(32'h100, 32'h100);
    ovr_base = ovr_cnt;
    start_and_wait(0, 0, 0, "dflt");
    check_out("dflt", 24'd3, 24'd3, 24'd2, 24'd2);
    accept("dflt");
    chk("dflt_no_ovr", 64'(ovr_cnt - ovr_base), 64'd0);

    for (int i = 0; i < NVEC; i++) begin
      cfg_routes(vecs[i].mode, vecs[i].mute);
      set_data(vecs[i].d0, vecs[i].d1);
      ovr_base = ovr_cnt;
      start_and_wait(0, 0, 0, $sformatf("vec%0d", i));
      check_out($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3);
      accept($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_no_ovr", i), 64'(ovr_cnt - ovr_base), 64'd0);
    end

    // Two frames with the consumer stalled: second frame overwrites, one overrun.
    cfg_routes(2'd0, 10'h000);
    set_data(32'h100, 32'h100);
    ovr_base = ovr_cnt;
    start_and_wait(0, 0, 0, "stall_a");
    set_data(32'h200, 32'h200);
    start_and_wait(0, 0, 0, "stall_b");
    check_out("stall_b", 24'd6, 24'd6, 24'd4, 24'd4);
    accept("stall_b");
    chk("stall_ovr", 64'(ovr_cnt - ovr_base), 64'd1);

    // Consumer accepts the old frame in the LOAD cycle: no overrun.
    set_data(32'h100, 32'h100);
    ovr_base = ovr_cnt;
    start_and_wait(0, 0, 0, "ovl_a");
    set_data(32'h300, 32'h300);
    start_and_wait(0, 12, 0, "ovl_b");
    check_out("ovl_b", 24'd9, 24'd9, 24'd6, 24'd6);
    accept("ovl_b");
    chk("ovl_no_ovr", 64'(ovr_cnt - ovr_base), 64'd0);

    // Extra frame_start mid-frame is ignored but flagged.
    set_data(32'h100, 32'h100);
    ovr_base = ovr_cnt;
    start_and_wait(5, 0, 0, "fs_busy");
    check_out("fs_busy", 24'd3, 24'd3, 24'd2, 24'd2);
    accept("fs_busy");
    chk("fs_busy_ovr", 64'(ovr_cnt - ovr_base), 64'd1);

    // Route write landing on the voice being fetched affects only the next frame.
    start_and_wait(0, 0, 1, "cfg_same");
    check_out("cfg_same", 24'd3, 24'd3, 24'd2, 24'd2);
    accept("cfg_same");
    start_and_wait(0, 0, 0, "cfg_next");
    check_out("cfg_next", 24'd2, 24'd3, 24'd2, 24'd2);
    accept("cfg_next");

    // Reset during FETCH clears outputs and routes.
    cfg_routes(2'd1, 10'h000);
    start_and_wait(0, 0, 0, "pre_rst");
    check_out("pre_rst", 24'd10, 24'd0, 24'd0, 24'd0);
    frame_start = 1'b1;
    @(posedge Clk);
    #1;
    frame_start = 1'b0;
    repeat (3) begin
      @(posedge Clk);
      #1;
    end
    chk("mid_busy", 64'(busy), 64'd1);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_req", 64'(voice_req), 64'd0);
    chk("mid_rst_idx", 64'(voice_idx), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data[63:0]) | 64'(out_data[95:64]), 64'd0);
    chk("mid_rst_ovr", 64'(overrun), 64'd0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    ovr_base = ovr_cnt;
    start_and_wait(0, 0, 0, "post_rst");
    check_out("post_rst", 24'd3, 24'd3, 24'd2, 24'd2);
    accept("post_rst");
    chk("post_rst_no_ovr", 64'(ovr_cnt - ovr_base), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
